// File: rtl/alu_16b_if.sv
// alu_16b_if: operand/result bundle for the registered 32-bit ALU.
//   inA, inB   : operands (inB[4:0] doubles as shift amount)
//   alu_ctrl   : 4-bit operation select
//   alu_out    : registered 32-bit result
//   cond_code  : registered flags {ILL, P, V, C, N, Z}
// master drives operands/opcode and reads results; slave is the ALU.
interface alu_16b_if;
    logic [31:0] inA;
    logic [31:0] inB;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic [5:0]  cond_code;

    modport master (
        output inA,
        output inB,
        output alu_ctrl,
        input  alu_out,
        input  cond_code
    );

    modport slave (
        input  inA,
        input  inB,
        input  alu_ctrl,
        output alu_out,
        output cond_code
    );
endinterface

// File: rtl/alu_16b.sv
// alu_16b: registered 32-bit integer ALU for the MIPS_16b datapath.
// Samples operands and opcode every rising clk edge and registers the result
// and the condition codes one cycle later.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (outputs forced to zero)
//   bus    : alu_16b_if.slave (inA, inB, alu_ctrl in; alu_out, cond_code out)
// cond_code bits: [0] Z, [1] N, [2] C, [3] V, [4] P, [5] ILL.
// Optional feature: define ALU_16B_SLT_EN to enable SLT (0110) and SLTU (1110);
// without it those codes are treated as illegal.
module alu_16b (
    input  logic       clk,
    input  logic       rst_n,
    alu_16b_if.slave   bus
);

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b1101;
`ifdef ALU_16B_SLT_EN
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b1110;
`endif

    logic [31:0] r_alu_out;
    logic [5:0]  r_cond_code;

    logic [4:0]  w_sh;
    logic [32:0] w_add;
    logic [32:0] w_sub;
    logic [32:0] w_sll;
    logic [32:0] w_srl;
    logic        w_add_v;
    logic        w_sub_v;
    logic [31:0] w_res;
    logic        w_c;
    logic        w_v;
    logic        w_ill;
    logic [5:0]  w_cc;

    assign w_sh  = bus.inB[4:0];
    assign w_add = {1'b0, bus.inA} + {1'b0, bus.inB};
    // Bit 32 of the 33-bit difference is the unsigned borrow (A < B).
    assign w_sub = {1'b0, bus.inA} - {1'b0, bus.inB};
    // One spare bit on each side of A catches the last bit shifted out;
    // with a zero shift that spare bit stays 0, so C = 0 falls out naturally.
    assign w_sll = {1'b0, bus.inA} << w_sh;
    assign w_srl = {bus.inA, 1'b0} >> w_sh;

    assign w_add_v = (bus.inA[31] == bus.inB[31]) && (w_add[31] != bus.inA[31]);
    assign w_sub_v = (bus.inA[31] != bus.inB[31]) && (w_sub[31] != bus.inA[31]);

`ifdef ALU_16B_SLT_EN
    logic w_slt;
    // Differing signs: A is less exactly when it is negative; otherwise the
    // unsigned borrow gives the signed answer too.
    assign w_slt = (bus.inA[31] != bus.inB[31]) ? bus.inA[31] : w_sub[32];
`endif

    always_comb begin
        w_res = 32'h0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (bus.alu_ctrl)
            OP_PASS: w_res = bus.inA;
            OP_ADD: begin
                w_res = w_add[31:0];
                w_c   = w_add[32];
                w_v   = w_add_v;
            end
            OP_SUB: begin
                w_res = w_sub[31:0];
                w_c   = w_sub[32];
                w_v   = w_sub_v;
            end
            OP_XOR:  w_res = bus.inA ^ bus.inB;
            OP_NOR:  w_res = ~(bus.inA | bus.inB);
            OP_AND:  w_res = bus.inA & bus.inB;
            OP_OR:   w_res = bus.inA | bus.inB;
            OP_SLL: begin
                w_res = w_sll[31:0];
                w_c   = w_sll[32];
            end
            OP_SRL: begin
                w_res = w_srl[32:1];
                w_c   = w_srl[0];
            end
`ifdef ALU_16B_SLT_EN
            OP_SLT: begin
                w_res = {31'h0, w_slt};
                w_c   = w_sub[32];
                w_v   = w_sub_v;
            end
            OP_SLTU: begin
                w_res = {31'h0, w_sub[32]};
                w_c   = w_sub[32];
                w_v   = w_sub_v;
            end
`endif
            default: w_ill = 1'b1;
        endcase
    end

    assign w_cc = {w_ill, ^w_res, w_v, w_c, w_res[31], (w_res == 32'h0)};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_out   <= 32'h0;
            r_cond_code <= 6'b000000;
        end else begin
            r_alu_out   <= w_res;
            r_cond_code <= w_cc;
        end
    end

    assign bus.alu_out   = r_alu_out;
    assign bus.cond_code = r_cond_code;

endmodule

// File: tb/tb_alu_16b.sv
// tb_alu_16b: scoreboard bench for alu_16b. Each driven cycle pushes its
// expected result/flags; a monitor pops one entry per clock edge and compares.
module tb_alu_16b;

    typedef struct {
        logic [31:0] out;
        logic [5:0]  cc;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    alu_16b_if u_bus ();

    alu_16b u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: {out[31:0], ILL, P, V, C, N, Z}
    function automatic logic [37:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        logic [31:0] r;
        logic        c, v, ill;
        longint      sa, sb, sr;
        int          sh;
        r = 32'h0; c = 1'b0; v = 1'b0; ill = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        sr = 0;
        case (op)
            4'b0000: r = a;
            4'b0001: begin
                r = a + b;
                c = (({32'h0, a} + {32'h0, b}) > 64'hFFFF_FFFF);
                sr = sa + sb;
                v = (sr != longint'($signed(r)));
            end
            4'b1001: begin
                r = a - b;
                c = (a < b);
                sr = sa - sb;
                v = (sr != longint'($signed(r)));
            end
            4'b0010: r = a ^ b;
            4'b1010: r = ~(a | b);
            4'b0011: r = a & b;
            4'b0100: r = a | b;
            4'b0101: begin
                r = a;
                for (int i = 0; i < sh; i++) begin
                    c = r[31];
                    r = {r[30:0], 1'b0};
                end
            end
            4'b1101: begin
                r = a;
                for (int i = 0; i < sh; i++) begin
                    c = r[0];
                    r = {1'b0, r[31:1]};
                end
            end
`ifdef ALU_16B_SLT_EN
            4'b0110, 4'b1110: begin
                if (op == 4'b0110) r = (sa < sb) ? 32'h1 : 32'h0;
                else               r = (a < b) ? 32'h1 : 32'h0;
                c = (a < b);
                sr = sa - sb;
                v = (sr != longint'($signed(a - b)));
            end
`endif
            default: ill = 1'b1;
        endcase
        return {r, ill, ^r, v, c, r[31], (r == 32'h0)};
    endfunction

    // Drive one cycle and push its expectation; returns on the next negedge.
    task automatic issue_k(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [31:0] e_out, input logic [5:0] e_cc);
        exp_t e;
        u_bus.inA = a;
        u_bus.inB = b;
        u_bus.alu_ctrl = op;
        e.out = e_out; e.cc = e_cc; e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic issue_m(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        logic [37:0] m;
        m = model(a, b, op);
        issue_k(tag, a, b, op, m[37:6], m[5:0]);
    endtask

    task automatic do_reset(input string tag, input logic [31:0] a);
        rst_n = 1'b0;
        issue_k(tag, a, 32'hFFFF_FFFF, 4'b0001, 32'h0, 6'b000000);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".out"}, u_bus.alu_out, e.out);
                chk({e.tag, ".cc"}, {26'h0, u_bus.cond_code}, {26'h0, e.cc});
            end
        end
    end

    initial begin : driver
        logic [31:0] a, b;
        logic [3:0]  op;
        logic [31:0] edge_v[6];
        edge_v[0] = 32'h0;        edge_v[1] = 32'hFFFF_FFFF;
        edge_v[2] = 32'h7FFF_FFFF; edge_v[3] = 32'h8000_0000;
        edge_v[4] = 32'h1;        edge_v[5] = 32'h20;

        u_bus.inA = 32'hFFFF_FFFF;
        u_bus.inB = 32'h0;
        u_bus.alu_ctrl = 4'b0001;
        rst_n = 1'b0;
        issue_k("rst0", 32'hFFFF_FFFF, 32'h0, 4'b0001, 32'h0, 6'b000000);
        issue_k("rst1", 32'hFFFF_FFFF, 32'h0, 4'b0001, 32'h0, 6'b000000);
        rst_n = 1'b1;
        issue_k("add_zero", 32'h0, 32'h0, 4'b0001, 32'h0, 6'b000001);

        issue_k("seq_add", 32'h10, 32'h2, 4'b0001, 32'h12, 6'b000000);
        issue_k("seq_sub", 32'h10, 32'h2, 4'b1001, 32'h0E, 6'b010000);
        issue_k("seq_and", 32'h10, 32'h2, 4'b0011, 32'h0,  6'b000001);
        issue_k("seq_or",  32'h10, 32'h2, 4'b0100, 32'h12, 6'b000000);
        issue_k("seq_sll", 32'h10, 32'h2, 4'b0101, 32'h40, 6'b010000);
        issue_k("seq_srl", 32'h10, 32'h2, 4'b1101, 32'h4,  6'b010000);

        issue_k("add_ovf",   32'h7FFF_FFFF, 32'h1, 4'b0001, 32'h8000_0000, 6'b011010);
        issue_k("add_carry", 32'hFFFF_FFFF, 32'h1, 4'b0001, 32'h0,         6'b000101);
        issue_k("sub_borrow", 32'h2, 32'h10, 4'b1001, 32'hFFFF_FFF2, 6'b010110);
        issue_k("sub_ovf", 32'h8000_0000, 32'h1, 4'b1001, 32'h7FFF_FFFF, 6'b011000);
        issue_k("sll_c", 32'h8000_0001, 32'h1, 4'b0101, 32'h2, 6'b010100);
        issue_k("srl_c", 32'h1, 32'h1, 4'b1101, 32'h0, 6'b000101);
        issue_k("sll_sh0", 32'h1234_5678, 32'h20, 4'b0101, 32'h1234_5678, 6'b010000);
        issue_k("illegal", 32'h1234_5678, 32'h1, 4'b0111, 32'h0, 6'b100001);
`ifdef ALU_16B_SLT_EN
        issue_k("slt",  32'hFFFF_FFFF, 32'h1, 4'b0110, 32'h1, 6'b010000);
        issue_k("sltu", 32'hFFFF_FFFF, 32'h1, 4'b1110, 32'h0, 6'b000001);
`else
        issue_k("slt",  32'hFFFF_FFFF, 32'h1, 4'b0110, 32'h0, 6'b100001);
        issue_k("sltu", 32'hFFFF_FFFF, 32'h1, 4'b1110, 32'h0, 6'b100001);
`endif
        issue_k("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0010, 32'h0FF0_0FF0, 6'b000000);
        issue_k("nor", 32'h0, 32'h0, 4'b1010, 32'hFFFF_FFFF, 6'b000010);
        issue_k("pass", 32'h8000_0000, 32'h5, 4'b0000, 32'h8000_0000, 6'b010010);

        issue_m("pre_rst", 32'h1234_5678, 32'h1111_1111, 4'b0001);
        issue_m("inflight", 32'hDEAD_BEEF, 32'h1, 4'b0100);
        do_reset("mid_rst", 32'hFFFF_FFFF);
        issue_m("post_rst", 32'h5, 32'h7, 4'b1001);

        for (int i = 0; i < 300; i++) begin
            a  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            op = 4'($urandom_range(0, 15));
            issue_m("rand", a, b, op);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
